uart_wb_koprusu: RTL and testbench

UART_WB_KOPRUSU -- requirements
Module: uart_wb_koprusu

---
 rtl/uart_wb_koprusu.sv | 122 ++++++++++++
 tb/tb_uart_wb_koprusu.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_koprusu.sv
// UART-to-Wishbone bridge: byte-framed read/write commands popped from an RX
// FIFO become single Wishbone cycles; response bytes are pushed to a TX FIFO.
module uart_wb_koprusu #(
  parameter logic [15:0] WB_TIMEOUT = 16'd1024,
  parameter logic [7:0]  CMD_WR     = 8'h57,
  parameter logic [7:0]  CMD_RD     = 8'h52
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_empty_i,
  output logic        rx_re_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_full_i,
  output logic        tx_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  output logic        busy_o
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt, resp_left;
  logic [15:0] tmo_cnt;
  logic [31:0] resp_q;
  logic        is_wr, rx_gap, tx_gap;
  logic        rx_phase, is_cmd, last_byte, tmo_hit;

  assign rx_phase  = (state == IDLE) || (state == ADDR) || (state == DATA);
  // rx_gap resets high so nothing is popped while reset is held
  assign rx_re_o   = rx_phase && !rx_empty_i && !rx_gap;
  assign tx_we_o   = (state == RESP) && !tx_full_i && !tx_gap;
  assign tx_data_o = (state == RESP) ? resp_q[7:0] : 8'h00;
  assign wb_sel_o  = {4{wb_cyc_o}};
  assign busy_o    = (state != IDLE);
  assign is_cmd    = (rx_data_i == CMD_WR) || (rx_data_i == CMD_RD);
  assign last_byte = rx_re_o && (byte_cnt == 2'd3);
  // ack on the final count cycle still counts as success
  assign tmo_hit   = !wb_ack_i && (tmo_cnt == WB_TIMEOUT - 16'd1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_re_o) state_nxt = is_cmd ? ADDR : RESP;
      ADDR:    if (last_byte) state_nxt = is_wr ? DATA : BUS;
      DATA:    if (last_byte) state_nxt = BUS;
      BUS:     if (wb_ack_i || tmo_hit) state_nxt = RESP;
      RESP:    if (tx_we_o && resp_left == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      byte_cnt  <= 2'd0;
      resp_left <= 2'd0;
      tmo_cnt   <= 16'd0;
      resp_q    <= 32'd0;
      is_wr     <= 1'b0;
      rx_gap    <= 1'b1;
      tx_gap    <= 1'b0;
      wb_adr_o  <= 32'd0;
      wb_dat_o  <= 32'd0;
      wb_we_o   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
    end else begin
      rx_gap <= rx_re_o;
      tx_gap <= tx_we_o;
      case (state)
        IDLE: if (rx_re_o) begin
          is_wr     <= (rx_data_i == CMD_WR);
          byte_cnt  <= 2'd0;
          resp_q    <= {24'd0, 8'h3F};
          resp_left <= 2'd0;
        end
        ADDR, DATA: if (rx_re_o) begin
          byte_cnt <= byte_cnt + 2'd1;
          if (state == ADDR) wb_adr_o <= {rx_data_i, wb_adr_o[31:8]};
          else               wb_dat_o <= {rx_data_i, wb_dat_o[31:8]};
          if (last_byte && (state == DATA || !is_wr)) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= is_wr;
            tmo_cnt  <= 16'd0;
          end
        end
        BUS: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (wb_ack_i || tmo_hit) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
          end
          if (wb_ack_i) begin
            resp_q    <= is_wr ? {24'd0, 8'h4B} : wb_dat_i;
            resp_left <= is_wr ? 2'd0 : 2'd3;
          end else if (tmo_hit) begin
            resp_q    <= {24'd0, 8'h45};
            resp_left <= 2'd0;
          end
        end
        RESP: if (tx_we_o) begin
          resp_q    <= {8'd0, resp_q[31:8]};
          resp_left <= resp_left - 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_wb_koprusu.sv
// Bench for uart_wb_koprusu: FIFO/slave models, directed table, random frames
// against a frame-level reference model, and reset/back-pressure sequences.
module tb_uart_wb_koprusu;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_empty_i = 1'b1;
  logic        rx_re_o;
  logic [7:0]  tx_data_o;
  logic        tx_full_i = 1'b0;
  logic        tx_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = 32'd0;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0;
  logic        busy_o;

  uart_wb_koprusu #(.WB_TIMEOUT(16'd8)) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_empty_i(rx_empty_i),
    .rx_re_o(rx_re_o), .tx_data_o(tx_data_o), .tx_full_i(tx_full_i), .tx_we_o(tx_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0][7:0] frm;
    int              n;
    logic [31:0]     rd;
    int              lat;
    logic [3:0][7:0] etx;
    int              entx;
    int              ebus;
    logic [31:0]     eadr, edat;
    logic            ewe;
    int              ecyc;
  } vec_t;

  int checks = 0, errors = 0;
  // rx FIFO: main writes rx_mem/rx_wr, monitor advances pop_cnt
  logic [7:0]  rx_mem [1024];
  int          rx_wr = 0, pop_cnt = 0;
  logic [7:0]  tx_mem [1024];
  int          tx_cnt = 0;
  logic [31:0] bus_adr [256], bus_dat [256];
  logic        bus_we [256];
  int          bus_cnt = 0, cyc_total = 0, viol = 0, viol_base = 0;
  logic        prev_re = 1'b0, prev_we = 1'b0;
  int          ack_lat = 0, scnt = 0;
  logic [31:0] rd_data = 32'd0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // FIFO head presentation and Wishbone slave, updated just after each edge
  always @(posedge clk) begin
    #1;
    rx_empty_i = (rx_wr == pop_cnt);
    rx_data_i  = rx_empty_i ? 8'h00 : rx_mem[pop_cnt];
    wb_dat_i   = rd_data;
    if (wb_cyc_o && !wb_ack_i) begin
      scnt++;
      if (scnt == ack_lat + 1) wb_ack_i = 1'b1;
    end else begin
      wb_ack_i = 1'b0;
      if (!wb_cyc_o) scnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_i && (rx_re_o || tx_we_o || wb_cyc_o || busy_o)) begin
      viol++; $display("protocol violation: active output during reset at %0t", $time);
    end
    if (rx_re_o && rx_empty_i) begin viol++; $display("protocol violation: pop of empty rx at %0t", $time); end
    if (rx_re_o && prev_re)    begin viol++; $display("protocol violation: back-to-back pop at %0t", $time); end
    if (tx_we_o && tx_full_i)  begin viol++; $display("protocol violation: push into full tx at %0t", $time); end
    if (tx_we_o && prev_we)    begin viol++; $display("protocol violation: back-to-back push at %0t", $time); end
    if (wb_sel_o != {4{wb_cyc_o}}) begin viol++; $display("protocol violation: sel %h at %0t", wb_sel_o, $time); end
    if (rx_re_o && rst_i) pop_cnt++;
    if (tx_we_o) begin tx_mem[tx_cnt] = tx_data_o; tx_cnt++; end
    if (wb_cyc_o) cyc_total++;
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      bus_adr[bus_cnt] = wb_adr_o; bus_dat[bus_cnt] = wb_dat_o; bus_we[bus_cnt] = wb_we_o;
      bus_cnt++;
    end
    prev_re = rx_re_o;
    prev_we = tx_we_o;
  end

  function automatic vec_t mk(input logic [71:0] frm, input int n, input logic [31:0] rd,
                              input int lat, input logic [31:0] etx, input int entx, input int ebus,
                              input logic [31:0] eadr, input logic [31:0] edat, input logic ewe,
                              input int ecyc);
    vec_t v;
    v.frm = frm; v.n = n; v.rd = rd; v.lat = lat; v.etx = etx; v.entx = entx;
    v.ebus = ebus; v.eadr = eadr; v.edat = edat; v.ewe = ewe; v.ecyc = ecyc;
    return v;
  endfunction

  // Frame-level reference: what the bridge must answer for a given frame/slave
  function automatic vec_t model(input logic [7:0] cmd, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [31:0] rd, input int lat);
    vec_t v;
    v.frm = '0; v.etx = '0; v.frm[0] = cmd; v.n = 1; v.rd = rd; v.lat = lat;
    v.eadr = adr; v.edat = dat; v.ewe = (cmd == 8'h57); v.ebus = 0; v.ecyc = 0;
    v.entx = 1; v.etx[0] = 8'h3F;
    if (cmd == 8'h57 || cmd == 8'h52) begin
      for (int i = 0; i < 4; i++) v.frm[1+i] = adr[8*i +: 8];
      v.n = 5;
      if (cmd == 8'h57) begin
        for (int i = 0; i < 4; i++) v.frm[5+i] = dat[8*i +: 8];
        v.n = 9;
      end
      if (lat + 1 <= TMO) begin
        v.ebus = 1; v.ecyc = lat + 1;
        if (cmd == 8'h57) v.etx[0] = 8'h4B;
        else begin
          for (int i = 0; i < 4; i++) v.etx[i] = rd[8*i +: 8];
          v.entx = 4;
        end
      end else begin
        v.ecyc = TMO; v.etx[0] = 8'h45;
      end
    end
    return v;
  endfunction

  task automatic push(input logic [7:0] b);
    rx_mem[rx_wr] = b;
    rx_wr++;
  endtask

  task automatic run(input vec_t v, input int split);
    int tb0, bb0, cb0, done;
    tb0 = tx_cnt; bb0 = bus_cnt; cb0 = cyc_total;
    ack_lat = v.lat; rd_data = v.rd;
    for (int i = 0; i < v.n; i++) begin
      if (split != 0 && i == split) begin
        repeat (30) @(negedge clk);
        chk("pause_busy", {31'd0, busy_o}, 32'd1);
        chk("pause_no_bus", cyc_total - cb0 + tx_cnt - tb0, 32'd0);
      end
      push(v.frm[i]);
    end
    done = 0;
    for (int c = 0; c < 3000 && done == 0; c++) begin
      @(negedge clk);
      if (!busy_o && rx_wr == pop_cnt && tx_cnt - tb0 >= v.entx) done = 1;
    end
    chk("frame_done", done, 32'd1);
    repeat (2) @(negedge clk);
    chk("tx_count", tx_cnt - tb0, v.entx);
    for (int i = 0; i < v.entx && i < 4; i++) chk("tx_byte", {24'd0, tx_mem[tb0+i]}, {24'd0, v.etx[i]});
    chk("bus_count", bus_cnt - bb0, v.ebus);
    if (v.ebus != 0 && bus_cnt > bb0) begin
      chk("bus_adr", bus_adr[bb0], v.eadr);
      chk("bus_we", {31'd0, bus_we[bb0]}, {31'd0, v.ewe});
      if (v.ewe) chk("bus_dat", bus_dat[bb0], v.edat);
    end
    chk("cyc_cycles", cyc_total - cb0, v.ecyc);
    chk("protocol", viol - viol_base, 32'd0);
    viol_base = viol;
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v;
    int   tb0, bb0, ok, r;
    logic [7:0] cmd;

    tbl[0] = mk(72'hDEADBEEF_20000000_57, 9, 32'h0, 1, 32'h4B, 1, 1, 32'h20000000, 32'hDEADBEEF, 1'b1, 2);
    tbl[1] = mk(72'h20000004_52, 5, 32'h12345678, 0, 32'h12345678, 4, 1, 32'h20000004, 32'h0, 1'b0, 1);
    tbl[2] = mk(72'hAA, 1, 32'h0, 0, 32'h3F, 1, 0, 32'h0, 32'h0, 1'b0, 0);
    tbl[3] = mk(72'h11223344_00000100_57, 9, 32'h0, 255, 32'h45, 1, 0, 32'h0, 32'h0, 1'b1, 8);
    tbl[4] = mk(72'h000000FC_52, 5, 32'hCAFEF00D, 7, 32'hCAFEF00D, 4, 1, 32'h000000FC, 32'h0, 1'b0, 8);
    tbl[5] = mk(72'h00000040_52, 5, 32'h55555555, 8, 32'h45, 1, 0, 32'h0, 32'h0, 1'b0, 8);
    tbl[6] = mk(72'h0BADF00D_12345678_57, 9, 32'h0, 3, 32'h4B, 1, 1, 32'h12345678, 32'h0BADF00D, 1'b1, 4);

    // reset state, with a byte already waiting in the rx FIFO
    push(8'hAA);
    repeat (3) @(negedge clk);
    chk("rst_rx_re", {31'd0, rx_re_o}, 32'd0);
    chk("rst_tx_we", {31'd0, tx_we_o}, 32'd0);
    chk("rst_bus_ctl", {28'd0, wb_cyc_o, wb_stb_o, wb_we_o, busy_o}, 32'd0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
    chk("rst_no_pop", pop_cnt, 32'd0);
    @(posedge clk); #1 rst_i = 1'b1;
    ok = 0;
    for (int c = 0; c < 200 && ok == 0; c++) begin
      @(negedge clk);
      if (tx_cnt >= 1 && !busy_o) ok = 1;
    end
    chk("post_rst_done", ok, 32'd1);
    chk("post_rst_resp", {24'd0, tx_mem[0]}, 32'h3F);

    foreach (tbl[i]) run(tbl[i], 0);

    // stalled frame: waits indefinitely mid-address
    run(tbl[0], 4);

    // tx back-pressure during a read response; a new rx byte must stay queued
    tb0 = tx_cnt; bb0 = bus_cnt;
    @(posedge clk); #1 tx_full_i = 1'b1;
    ack_lat = 3; rd_data = 32'hA1B2C3D4;
    push(8'h52); push(8'h10); push(8'h00); push(8'h00); push(8'h00);
    ok = 0;
    for (int c = 0; c < 500 && ok == 0; c++) begin
      @(negedge clk);
      if (bus_cnt > bb0) ok = 1;
    end
    chk("full_bus_done", ok, 32'd1);
    push(8'hAA);
    repeat (20) @(negedge clk);
    chk("full_no_tx", tx_cnt - tb0, 32'd0);
    chk("full_rx_held", rx_wr - pop_cnt, 32'd1);
    @(posedge clk); #1 tx_full_i = 1'b0;
    ok = 0;
    for (int c = 0; c < 500 && ok == 0; c++) begin
      @(negedge clk);
      if (tx_cnt - tb0 >= 5 && !busy_o) ok = 1;
    end
    chk("full_release_done", ok, 32'd1);
    chk("full_b0", {24'd0, tx_mem[tb0]},   32'hD4);
    chk("full_b1", {24'd0, tx_mem[tb0+1]}, 32'hC3);
    chk("full_b2", {24'd0, tx_mem[tb0+2]}, 32'hB2);
    chk("full_b3", {24'd0, tx_mem[tb0+3]}, 32'hA1);
    chk("full_next", {24'd0, tx_mem[tb0+4]}, 32'h3F);

    // reset in the middle of a bus cycle
    ack_lat = 255;
    for (int i = 0; i < 9; i++) push(tbl[3].frm[i]);
    ok = 0;
    for (int c = 0; c < 200 && ok == 0; c++) begin
      @(negedge clk);
      if (wb_cyc_o) ok = 1;
    end
    chk("midbus_started", ok, 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_i = 1'b0;
    #1;
    chk("midbus_cyc", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("midbus_busy", {31'd0, busy_o}, 32'd0);
    chk("midbus_sel", {28'd0, wb_sel_o}, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_i = 1'b1;
    viol_base = viol;
    run(tbl[0], 0);

    // randomized frames against the reference model
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      cmd = 8'h57;
      else if (r < 8) cmd = 8'h52;
      else begin
        cmd = 8'($urandom);
        if (cmd == 8'h57 || cmd == 8'h52) cmd = 8'h00;
      end
      v = model(cmd, $urandom, $urandom, $urandom, $urandom_range(0, 10));
      run(v, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
